// File: rtl/coin_change_scheduler.sv
// Return-wait timer and greedy change dispenser for the vending machine.
// Each DISPENSE cycle names one coin and its value for the parent to subtract.
module coin_change_scheduler #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    i_select_item,
  input  logic                    i_trigger_return,
  input  logic [TOTAL_BITS-1:0]   i_current_total,
  input  logic [NUM_ITEMS*32-1:0] i_item_price,
  input  logic [NUM_COINS*32-1:0] i_coin_value,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic [TOTAL_BITS-1:0]   o_dec_amount,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_wait_time
);

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

  state_t                state_reg, state_next;
  logic [TOTAL_BITS-1:0] remaining_reg, remaining_next;
  logic [31:0]           wait_time_reg, wait_time_next;

  logic [TOTAL_BITS-1:0] coin_val [NUM_COINS];
  logic [TOTAL_BITS-1:0] price    [NUM_ITEMS];

  // Only the low TOTAL_BITS of each 32-bit value take part in the arithmetic.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COINS; gi++) begin : g_coin
      assign coin_val[gi] = i_coin_value[32*gi +: TOTAL_BITS];
      if (TOTAL_BITS < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^i_coin_value[32*gi+TOTAL_BITS +: 32-TOTAL_BITS];
      end
    end
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
      assign price[gi] = i_item_price[32*gi +: TOTAL_BITS];
      if (TOTAL_BITS < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^i_item_price[32*gi+TOTAL_BITS +: 32-TOTAL_BITS];
      end
    end
  endgenerate

  // Descending scan so the lowest selected item has the final say.
  logic purchase_ok;
  always_comb begin
    purchase_ok = 1'b0;
    for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
      if (i_select_item[k]) purchase_ok = (price[k] <= i_current_total);
    end
  end

  logic [NUM_COINS-1:0]  coin_onehot;
  logic [TOTAL_BITS-1:0] coin_amt;
  always_comb begin
    coin_onehot = '0;
    coin_amt    = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_val[k] != '0 && coin_val[k] <= remaining_reg) begin
        coin_onehot    = '0;
        coin_onehot[k] = 1'b1;
        coin_amt       = coin_val[k];
      end
    end
  end

  // Look ahead so the cycle after the last coin is already DONE.
  logic [TOTAL_BITS-1:0] rem_after;
  logic                  more_coins;
  assign rem_after = remaining_reg - coin_amt;
  always_comb begin
    more_coins = 1'b0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_val[k] != '0 && coin_val[k] <= rem_after) more_coins = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      wait_time_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      wait_time_reg <= wait_time_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    wait_time_next = wait_time_reg;
    o_return_coin  = '0;
    o_dec_amount   = '0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|i_input_coin || purchase_ok) begin
          wait_time_next = 32'(WAIT_TIME);
        end else if (i_trigger_return && i_current_total != '0) begin
          remaining_next = i_current_total;
          wait_time_next = '0;
          state_next     = DISPENSE;
        end else if (i_trigger_return) begin
          wait_time_next = '0;
        end else if (wait_time_reg == 32'd1 && i_current_total != '0) begin
          remaining_next = i_current_total;
          wait_time_next = '0;
          state_next     = DISPENSE;
        end else if (wait_time_reg != '0) begin
          wait_time_next = wait_time_reg - 32'd1;
        end
      end
      DISPENSE: begin
        o_busy         = 1'b1;
        wait_time_next = '0;
        if (coin_onehot != '0) begin
          o_return_coin  = coin_onehot;
          o_dec_amount   = coin_amt;
          remaining_next = rem_after;
          if (!more_coins) state_next = DONE;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_busy         = 1'b1;
        o_done         = 1'b1;
        wait_time_next = '0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_wait_time = wait_time_reg;

endmodule

// File: tb/tb_coin_change_scheduler.sv
// Directed bench for coin_change_scheduler: expected outputs are queued when
// stimulus is driven and popped/compared one cycle at a time.
module tb_coin_change_scheduler;
  localparam int NC = 3, NI = 4, TBITS = 31, WT = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NC-1:0]    i_input_coin = '0;
  logic [NI-1:0]    i_select_item = '0;
  logic             i_trigger_return = 1'b0;
  logic [TBITS-1:0] i_current_total = '0;
  logic [NI*32-1:0] i_item_price = {32'd2000, 32'd1000, 32'd500, 32'd400};
  logic [NC*32-1:0] i_coin_value = {32'd1000, 32'd500, 32'd100};
  logic [NC-1:0]    o_return_coin;
  logic [TBITS-1:0] o_dec_amount;
  logic             o_busy, o_done;
  logic [31:0]      o_wait_time;

  coin_change_scheduler #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TBITS), .WAIT_TIME(WT)) dut (
    .clk(clk), .reset_n(reset_n), .i_input_coin(i_input_coin), .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return), .i_current_total(i_current_total),
    .i_item_price(i_item_price), .i_coin_value(i_coin_value), .o_return_coin(o_return_coin),
    .o_dec_amount(o_dec_amount), .o_busy(o_busy), .o_done(o_done), .o_wait_time(o_wait_time)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0]    coin;
    logic [TBITS-1:0] amt;
    logic             busy;
    logic             done;
    logic [31:0]      wt;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [NC-1:0] c, input int a, input logic b, input logic d, input int w);
    exp_t e;
    e.coin = c; e.amt = TBITS'(a); e.busy = b; e.done = d; e.wt = 32'(w);
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: observed=output expected=queued entry", tag);
    end else begin
      e = sb_q.pop_front();
      $display("%s: coin=%b amt=%0d busy=%b done=%b wt=%0d", tag, o_return_coin, o_dec_amount,
               o_busy, o_done, o_wait_time);
      cmp({tag, ".coin"}, 32'(o_return_coin), 32'(e.coin));
      cmp({tag, ".amt"},  32'(o_dec_amount),  32'(e.amt));
      cmp({tag, ".busy"}, 32'(o_busy),        32'(e.busy));
      cmp({tag, ".done"}, 32'(o_done),        32'(e.done));
      cmp({tag, ".wt"},   o_wait_time,        e.wt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Greedy reference: largest coin first, then one DONE cycle, then idle.
  task automatic push_greedy(input int total);
    int vals[NC];
    int rem;
    vals[0] = 100; vals[1] = 500; vals[2] = 1000;
    rem = total;
    if (rem < vals[0]) push('0, 0, 1'b1, 1'b0, 0);
    while (rem >= vals[0]) begin
      for (int k = NC - 1; k >= 0; k--) begin
        if (vals[k] <= rem) begin
          push(NC'(1 << k), vals[k], 1'b1, 1'b0, 0);
          rem -= vals[k];
          break;
        end
      end
    end
    push('0, 0, 1'b1, 1'b1, 0);
    push('0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic run_dispense(input string tag, input int total);
    int n;
    i_current_total  = TBITS'(total);
    i_trigger_return = 1'b1;
    step();
    i_trigger_return = 1'b0;
    push_greedy(total);
    n = sb_q.size();
    check(tag);
    for (int i = 1; i < n; i++) begin
      step();
      check(tag);
    end
  endtask

  initial begin
    @(negedge clk);
    push('0, 0, 1'b0, 1'b0, 0);
    check("reset");
    reset_n = 1'b1;
    step();
    push('0, 0, 1'b0, 1'b0, 0);
    check("post_reset_idle");

    run_dispense("disp1600", 1600);
    run_dispense("disp2200", 2200);
    run_dispense("disp150", 150);
    run_dispense("disp50", 50);

    // Timeout path: countdown from reload to dispense.
    i_current_total = 500;
    i_input_coin = 3'b010;
    step();
    i_input_coin = '0;
    push('0, 0, 1'b0, 1'b0, WT);
    check("timer_reload");
    for (int v = WT - 1; v >= 1; v--) begin
      step();
      push('0, 0, 1'b0, 1'b0, v);
      check("timer_count");
    end
    step();
    push(3'b010, 500, 1'b1, 1'b0, 0);
    check("timeout_coin");
    step();
    push('0, 0, 1'b1, 1'b1, 0);
    check("timeout_done");
    step();
    push('0, 0, 1'b0, 1'b0, 0);
    check("timeout_idle");

    // Reload at count 4 prevents dispense.
    i_input_coin = 3'b001;
    step();
    i_input_coin = '0;
    push('0, 0, 1'b0, 1'b0, WT);
    check("reload2");
    for (int v = WT - 1; v >= 4; v--) begin
      step();
      push('0, 0, 1'b0, 1'b0, v);
      check("count_to4");
    end
    i_input_coin = 3'b100;
    step();
    i_input_coin = '0;
    push('0, 0, 1'b0, 1'b0, WT);
    check("reload_at4");

    // Purchases: valid reloads, overpriced keeps counting.
    step();
    push('0, 0, 1'b0, 1'b0, WT - 1);
    check("pre_select");
    i_current_total = 600; i_select_item = 4'b0010;
    step();
    push('0, 0, 1'b0, 1'b0, WT);
    check("select_ok");
    i_current_total = 400;
    step();
    push('0, 0, 1'b0, 1'b0, WT - 1);
    check("select_poor");
    i_current_total = 500;
    step();
    push('0, 0, 1'b0, 1'b0, WT);
    check("select_equal");
    i_current_total = 600; i_select_item = 4'b1110;
    step();
    push('0, 0, 1'b0, 1'b0, WT);
    check("select_multi_low_ok");
    i_select_item = 4'b1100;
    step();
    push('0, 0, 1'b0, 1'b0, WT - 1);
    check("select_multi_low_poor");
    i_select_item = '0;

    // Coin plus trigger: reload wins.
    i_input_coin = 3'b001; i_trigger_return = 1'b1;
    step();
    i_input_coin = '0; i_trigger_return = 1'b0;
    push('0, 0, 1'b0, 1'b0, WT);
    check("coin_and_trigger");
    step();
    push('0, 0, 1'b0, 1'b0, WT - 1);
    check("coin_and_trigger_after");

    // Trigger with zero total clears timer only.
    i_current_total = 0; i_trigger_return = 1'b1;
    step();
    i_trigger_return = 1'b0;
    push('0, 0, 1'b0, 1'b0, 0);
    check("trigger_zero");
    step();
    push('0, 0, 1'b0, 1'b0, 0);
    check("trigger_zero_after");

    // Reset mid-dispense.
    i_current_total = 1600; i_trigger_return = 1'b1;
    step();
    i_trigger_return = 1'b0;
    push(3'b100, 1000, 1'b1, 1'b0, 0);
    check("pre_reset_coin");
    reset_n = 1'b0;
    #1;
    push('0, 0, 1'b0, 1'b0, 0);
    check("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    push('0, 0, 1'b0, 1'b0, 0);
    check("after_reset");
    step();
    push('0, 0, 1'b0, 1'b0, 0);
    check("after_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
